// File: rtl/toggle_mon_if.sv
// toggle_mon_if: stimulus input, run control and result bundle for toggle_mon
interface toggle_mon_if #(parameter int W = 16);
  logic in;
  logic start;
  logic busy;
  logic done;
  logic pass;
  logic timeout;
  logic [15:0] edge_cnt;
  logic [7:0] err_cnt;
  logic [W-1:0] last_width;
  modport master(output in, start, input busy, done, pass, timeout, edge_cnt, err_cnt, last_width);
  modport slave(input in, start, output busy, done, pass, timeout, edge_cnt, err_cnt, last_width);
endinterface

// File: rtl/toggle_mon.sv
// toggle_mon: synchronizes a toggling input, measures level widths against a half-period and reports pass/fail
module toggle_mon #(
  parameter int W           = 16,
  parameter int HALF_PERIOD = 10,
  parameter int TOL         = 1,
  parameter int EDGES       = 200,
  parameter int TIMEOUT     = 4 * HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  toggle_mon_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  localparam logic [W:0]   L_HP    = (W+1)'(HALF_PERIOD);
  localparam logic [W:0]   L_TOL   = (W+1)'(TOL);
  localparam logic [W-1:0] L_TMO   = W'(TIMEOUT);
  localparam logic [15:0]  L_EDGES = 16'(EDGES);
  state_t r_state;
  logic r_s1, r_s2, r_s3;
  logic r_busy, r_done, r_pass, r_timeout;
  logic [W-1:0] r_width, r_last_width;
  logic [15:0] r_edge_cnt;
  logic [7:0] r_err_cnt;
  logic w_edge, w_bad, w_tmo, w_accept, w_run;
  logic [W:0] w_wide, w_diff;
  assign w_edge   = r_s2 ^ r_s3;
  assign w_wide   = {1'b0, r_width};
  assign w_diff   = (w_wide >= L_HP) ? w_wide - L_HP : L_HP - w_wide;
  assign w_bad    = w_diff > L_TOL;
  assign w_tmo    = r_width == L_TMO;
  assign w_run    = (r_state == ARM) || (r_state == MEASURE);
  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_width      <= '0;
      r_last_width <= '0;
      r_edge_cnt   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_s1 <= bus.in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_accept) begin
        r_state      <= ARM;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_timeout    <= 1'b0;
        r_width      <= '0;
        r_last_width <= '0;
        r_edge_cnt   <= '0;
        r_err_cnt    <= '0;
      end else if (w_run) begin
        r_width <= w_edge ? W'(1) : (&r_width ? r_width : r_width + 1'b1);
        // the edge that reached EDGES was counted last cycle; close the run now
        if (r_state == MEASURE && r_edge_cnt == L_EDGES) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= r_err_cnt == 8'd0;
        end else if (w_edge) begin
          r_edge_cnt <= r_edge_cnt + 16'd1;
          r_state    <= MEASURE;
          if (r_state == MEASURE) begin
            r_last_width <= r_width;
            if (w_bad && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end else if (w_tmo) begin
          r_state   <= DONE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
          r_pass    <= 1'b0;
        end
      end
    end
  end
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.timeout    = r_timeout;
  assign bus.edge_cnt   = r_edge_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.last_width = r_last_width;
endmodule
